pipe_stage_buf: RTL and testbench

// Generic, parametrised pipeline-stage register for the CUPS datapath: successor to the fixed ID/EX buffer.

---
 rtl/pipe_stage_buf_pkg.sv | 40 ++++
 rtl/pipe_stage_buf_entry.sv | 43 ++++
 rtl/pipe_stage_buf.sv | 129 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the CUPS pipeline-stage buffers: control-bundle layout and NOP encoding.
package pipe_stage_buf_pkg;

  localparam int unsigned EX_FC_W  = 4;
  localparam int unsigned EX_AOI_W = 2;
  localparam int unsigned OP_W     = 5;

  // Bit offsets of each field inside the packed control bundle (LSB = regWrite).
  localparam int unsigned REG_WRITE_OFS = 0;
  localparam int unsigned OP2_OFS       = 1;
  localparam int unsigned OP1_OFS       = 6;
  localparam int unsigned WB_G_OFS      = 11;
  localparam int unsigned WB_F_OFS      = 12;
  localparam int unsigned MEM_SB_OFS    = 13;
  localparam int unsigned MEM_R_OFS     = 14;
  localparam int unsigned MEM_W_OFS     = 15;
  localparam int unsigned EX_AOI_OFS    = 16;
  localparam int unsigned EX_D_OFS      = 18;
  localparam int unsigned EX_C_OFS      = 19;
  localparam int unsigned EX_FC_OFS     = 20;

  typedef struct packed {
    logic [EX_FC_W-1:0]  ex_fc;
    logic                ex_c;
    logic                ex_d;
    logic [EX_AOI_W-1:0] ex_aoi;
    logic                mem_w;
    logic                mem_r;
    logic                mem_sb;
    logic                wb_f;
    logic                wb_g;
    logic [OP_W-1:0]     op1;
    logic [OP_W-1:0]     op2;
    logic                reg_write;
  } ctrl_t;

  localparam int unsigned CTRL_BITS = $bits(ctrl_t);
  localparam ctrl_t       CTRL_NOP  = '0;

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// One pipeline slot: valid flag plus payload and control, with load/clear/hold.
// A cleared slot always holds zero control so no enable can leak while invalid.
module pipe_stage_buf_entry #(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned CTRL_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Clear wins over load so a squash can never be overridden by steering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional skid slot,
// flush, bubble insertion and a saturating bubble counter.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned CTRL_W = CTRL_BITS,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam bit HAS_SKID = (SKID != 0);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              ready_base;
  logic              in_xfer, out_xfer, main_free;

  assign ready_base = HAS_SKID ? in_ready_q : (!main_v || out_ready);
  assign in_ready   = ready_base && !flush && !bubble;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = main_v && out_ready;
  assign main_free  = !main_v || out_xfer;

  // Steering: priority flush > bubble > normal; skid drains before new input to keep order.
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    cnt_d          = cnt_q;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (bubble) begin
      if (main_free) begin
        main_clr = 1'b1;
        cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end else if (main_free) begin
      if (skid_v) begin
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        skid_clr       = 1'b1;
      end else if (in_xfer) begin
        main_load = 1'b1;
      end else begin
        main_clr = 1'b1;
      end
    end else if (in_xfer && HAS_SKID) begin
      skid_load = 1'b1;
    end
    in_ready_d = flush ? 1'b1 : !(skid_load || (skid_v && !skid_clr));
  end

  assign main_data_d = main_from_skid ? skid_data : in_data;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  pipe_stage_buf_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clr),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .valid_o (main_v),
    .data_o  (main_data),
    .ctrl_o  (main_ctrl)
  );

  if (HAS_SKID) begin : g_skid
    pipe_stage_buf_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load_i  (skid_load),
      .clear_i (skid_clr),
      .data_i  (in_data),
      .ctrl_i  (in_ctrl),
      .valid_o (skid_v),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
    );
  end else begin : g_no_skid
    assign skid_v    = 1'b0;
    assign skid_data = '0;
    assign skid_ctrl = '0;
  end

  assign out_valid  = main_v;
  assign out_data   = main_data;
  assign out_ctrl   = main_ctrl;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf (SKID=1, CNT_W=2): vector table plus hand-written corner sequences.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int unsigned DATA_W = 48;
  localparam int unsigned CTRL_W = CTRL_BITS;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset, flush, bubble, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bubble     (bubble),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct {
    logic fl, bu, iv;
    int   k;
    logic ordy;
    logic e_rdy, e_ov;
    int   e_k;
    int   e_cnt;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  function automatic logic [DATA_W-1:0] dat(int k);
    if (k == 0) return '0;
    return {16'(32'hD000 + k), 16'(32'h1000 + k), 16'(32'h2000 + k)};
  endfunction

  function automatic logic [CTRL_W-1:0] ctl(int k);
    ctrl_t c;
    if (k == 0) return '0;
    c           = CTRL_NOP;
    c.reg_write = 1'b1;
    c.op1       = 5'(k);
    c.op2       = 5'(k + 1);
    c.ex_fc     = 4'(k);
    c.mem_w     = 1'(k);
    return c;
  endfunction

  function automatic vec_t mk(logic fl, logic bu, logic iv, int k, logic ordy,
                              logic e_rdy, logic e_ov, int e_k, int e_cnt);
    vec_t v;
    v.fl = fl; v.bu = bu; v.iv = iv; v.k = k; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_k = e_k; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(logic fl, logic bu, logic iv, int k, logic ordy);
    flush     = fl;
    bubble    = bu;
    in_valid  = iv;
    in_data   = dat(k);
    in_ctrl   = ctl(k);
    out_ready = ordy;
  endtask

  task automatic check_out(string tag, logic ov, int k, int cnt);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, ".out_data"}, 64'(out_data), 64'(dat(k)));
    chk({tag, ".out_ctrl"}, 64'(out_ctrl), 64'(ctl(k)));
    chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(cnt));
  endtask

  // Drive at negedge, sample in_ready before the edge and outputs just after it.
  task automatic step(string tag, vec_t v);
    @(negedge clk);
    drive(v.fl, v.bu, v.iv, v.k, v.ordy);
    #1;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(v.e_rdy));
    @(posedge clk);
    #1;
    check_out(tag, v.e_ov, v.e_k, v.e_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    //        fl    bu    iv    k   ordy  rdy   ov    ek  cnt
    // streaming A,B,C with no gaps
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1, 0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b1, 2, 0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b1, 3, 0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    // downstream stall: second item to skid, third held upstream, then drain in order
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b1, 4, 0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b1, 4, 0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b1, 4, 0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b1, 4, 0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 6, 1'b1, 1'b0, 1'b1, 5, 0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b1, 6, 0);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    // two bubbles with out_ready=1, then a bubble against a stalled main (holds)
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b1, 7, 0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0, 0, 1);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0, 0, 2);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b1, 1'b1, 8, 2);
    tbl[15] = mk(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8, 2);
    // flush with main+skid full and input offered; dropped item 10 must never appear
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b1, 8, 2);
    tbl[17] = mk(1'b1, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 0, 2);
    tbl[18] = mk(1'b0, 1'b0, 1'b1, 11, 1'b0, 1'b1, 1'b1, 11, 2);
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 12, 1'b0, 1'b1, 1'b1, 11, 2);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 12, 2);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 2);
    // bubble while skid is full: skid not promoted until bubble drops
    tbl[22] = mk(1'b0, 1'b0, 1'b1, 13, 1'b0, 1'b1, 1'b1, 13, 2);
    tbl[23] = mk(1'b0, 1'b0, 1'b1, 14, 1'b0, 1'b1, 1'b1, 13, 2);
    tbl[24] = mk(1'b0, 1'b1, 1'b1, 15, 1'b1, 1'b0, 1'b0, 0, 3);
    tbl[25] = mk(1'b0, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b1, 14, 3);
    tbl[26] = mk(1'b0, 1'b0, 1'b1, 15, 1'b1, 1'b1, 1'b1, 15, 3);
    tbl[27] = mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 3);

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.out_ctrl", 64'(out_ctrl), 64'(0));
    chk("rst.bubble_cnt", 64'(bubble_cnt), 64'(0));
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;

    for (int i = 0; i < NV; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Async reset mid-stream with both entries full: outputs clear without a clock edge.
    step("fill0", mk(1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b1, 20, 3));
    step("fill1", mk(1'b0, 1'b0, 1'b1, 21, 1'b0, 1'b1, 1'b1, 20, 3));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'(0));
    chk("arst.out_ctrl", 64'(out_ctrl), 64'(0));
    chk("arst.out_data", 64'(out_data), 64'(0));
    chk("arst.bubble_cnt", 64'(bubble_cnt), 64'(0));
    chk("arst.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    step("arst.post", mk(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 0, 0));

    // flush together with bubble: flush wins and the count does not move
    step("fb.load", mk(1'b0, 1'b0, 1'b1, 30, 1'b0, 1'b1, 1'b1, 30, 0));
    step("fb.both", mk(1'b1, 1'b1, 1'b1, 31, 1'b1, 1'b0, 1'b0, 0, 0));
    step("fb.after", mk(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 0, 0));

    // Five consecutive bubbles saturate a 2-bit counter at 3.
    for (int i = 1; i <= 5; i++)
      step($sformatf("sat%0d", i), mk(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, (i > 3) ? 3 : i));

    do_reset();
    #1;
    chk("rst2.bubble_cnt", 64'(bubble_cnt), 64'(0));

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
